// File: rtl/cache_data_array_if.sv
// rtl/cache_data_array_if.sv - store, read and refill signal bundle for cache_data_array
interface cache_data_array_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int BANK_ADDRESS = 2,
    parameter int INDEX_WIDTH  = 6
);
    logic                      write_i;
    logic [BANK_ADDRESS-1:0]   write_bank_i;
    logic [INDEX_WIDTH-1:0]    write_index_i;
    logic [DATA_WIDTH/8-1:0]   byte_write_i;
    logic [DATA_WIDTH-1:0]     data_i;
    logic                      write_stall_o;
    logic                      read_i;
    logic [BANK_ADDRESS-1:0]   read_bank_i;
    logic [INDEX_WIDTH-1:0]    read_index_i;
    logic [DATA_WIDTH-1:0]     data_o;
    logic                      valid_o;
    logic                      refill_start_i;
    logic [INDEX_WIDTH-1:0]    refill_index_i;
    logic [BANK_ADDRESS-1:0]   refill_bank_i;
    logic                      refill_valid_i;
    logic [DATA_WIDTH-1:0]     refill_data_i;
    logic                      refill_ready_o;
    logic                      refill_done_o;

    modport master (
        output write_i, write_bank_i, write_index_i, byte_write_i, data_i,
        output read_i, read_bank_i, read_index_i,
        output refill_start_i, refill_index_i, refill_bank_i, refill_valid_i, refill_data_i,
        input  write_stall_o, data_o, valid_o, refill_ready_o, refill_done_o
    );

    modport slave (
        input  write_i, write_bank_i, write_index_i, byte_write_i, data_i,
        input  read_i, read_bank_i, read_index_i,
        input  refill_start_i, refill_index_i, refill_bank_i, refill_valid_i, refill_data_i,
        output write_stall_o, data_o, valid_o, refill_ready_o, refill_done_o
    );
endinterface

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - banked cache data array with wrap-around line refill; CACHE_DATA_BYPASS_EN adds write-to-read forwarding
module cache_data_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int BANK_ADDRESS = 2,
    parameter int INDEX_WIDTH  = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    cache_data_array_if.slave bus
);
    localparam int BANK_NUMBER = 1 << BANK_ADDRESS;
    localparam int DEPTH       = 1 << INDEX_WIDTH;
    localparam int BYTES       = DATA_WIDTH / 8;
    localparam logic [BANK_ADDRESS:0] LAST_BEAT = (BANK_ADDRESS+1)'(BANK_NUMBER - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [BANK_ADDRESS-1:0] bank_q, bank_d;
    logic [BANK_ADDRESS:0]   beats_q, beats_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic                    done_q, done_d;
    logic                    beat_hs;

    logic                    wr_en;
    logic [BANK_ADDRESS-1:0] wr_bank;
    logic [INDEX_WIDTH-1:0]  wr_index;
    logic [BYTES-1:0]        wr_be;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [BANK_NUMBER-1:0]  wr_oh, rd_oh;

    logic [DATA_WIDTH-1:0]   mem_q [BANK_NUMBER][DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q [BANK_NUMBER];
    logic [BANK_ADDRESS-1:0] rbank_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   rword;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        beats_d = beats_q;
        index_d = index_q;
        done_d  = 1'b0;
        beat_hs = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.refill_start_i) begin
                    state_d = REFILL;
                    index_d = bus.refill_index_i;
                    bank_d  = bus.refill_bank_i;
                    beats_d = '0;
                end
            end
            REFILL: begin
                if (bus.refill_valid_i) begin
                    beat_hs = 1'b1;
                    bank_d  = bank_q + 1'b1;
                    beats_d = beats_q + 1'b1;
                    if (beats_q == LAST_BEAT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            bank_q  <= '0;
            beats_q <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            beats_q <= beats_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    // Refill beats own the write port; store hits only land while idle.
    always_comb begin
        wr_en    = 1'b0;
        wr_bank  = bus.write_bank_i;
        wr_index = bus.write_index_i;
        wr_be    = bus.byte_write_i;
        wr_data  = bus.data_i;
        if (beat_hs) begin
            wr_en    = 1'b1;
            wr_bank  = bank_q;
            wr_index = index_q;
            wr_be    = '1;
            wr_data  = bus.refill_data_i;
        end else if (state_q == IDLE && bus.write_i) begin
            wr_en = 1'b1;
        end
    end

    assign wr_oh = wr_en ? (BANK_NUMBER'(1) << wr_bank) : '0;
    assign rd_oh = bus.read_i ? (BANK_NUMBER'(1) << bus.read_bank_i) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            for (int b = 0; b < BANK_NUMBER; b++) begin
                for (int by = 0; by < BYTES; by++) begin
                    if (wr_oh[b] && wr_be[by])
                        mem_q[b][wr_index][by*8 +: 8] <= wr_data[by*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BANK_NUMBER; b++) begin
            if (rd_oh[b])
                rdata_q[b] <= mem_q[b][bus.read_index_i];
        end
        if (bus.read_i)
            rbank_q <= bus.read_bank_i;
        if (!rst_n_i)
            valid_q <= 1'b0;
        else
            valid_q <= bus.read_i;
    end

`ifdef CACHE_DATA_BYPASS_EN
    logic [BYTES-1:0]      byp_be_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            byp_be_q <= '0;
        end else if (bus.read_i) begin
            byp_be_q   <= (wr_en && wr_bank == bus.read_bank_i && wr_index == bus.read_index_i)
                          ? wr_be : '0;
            byp_data_q <= wr_data;
        end
    end

    always_comb begin
        rword = rdata_q[rbank_q];
        for (int by = 0; by < BYTES; by++) begin
            if (byp_be_q[by])
                rword[by*8 +: 8] = byp_data_q[by*8 +: 8];
        end
    end
`else
    assign rword = rdata_q[rbank_q];
`endif

    assign bus.data_o         = valid_q ? rword : '0;
    assign bus.valid_o        = valid_q;
    assign bus.refill_ready_o = (state_q == REFILL);
    assign bus.write_stall_o  = (state_q == REFILL);
    assign bus.refill_done_o  = done_q;
endmodule
